// File: rtl/nes_input_events.sv
// ============================================================================
// Module   : nes_input_events
// Purpose  : Polls the NES decoder and turns captured buttons into held levels
//            and press / release / auto-repeat event pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nes_input_events #(
  parameter int POLL_PERIOD  = 1000,
  parameter int TIMEOUT      = 64,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       in_clock,
  input  logic       reset,
  input  logic       poll_en,
  input  logic       ready_to_read,
  input  logic [7:0] buttons_n,
  output logic       read_data,
  output logic [7:0] pressed,
  output logic [7:0] press_evt,
  output logic [7:0] release_evt,
  output logic [7:0] repeat_evt,
  output logic       poll_done,
  output logic       timeout_evt
);

  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(TIMEOUT - 1);
  localparam logic [7:0]    RPT_TOP    = 8'(REPEAT_DELAY);
  localparam logic [7:0]    RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            read_q, read_d;
  logic            done_q, done_d;
  logic            tmo_q, tmo_d;
  logic [7:0]      pressed_q, pressed_d;
  logic [7:0]      press_q, press_d;
  logic [7:0]      release_q, release_d;
  logic [7:0]      repeat_q, repeat_d;
  logic [7:0]      rpt_q [8];
  logic [7:0]      rpt_d [8];
  logic [7:0]      w_new;

  assign w_new = ~buttons_n;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    phase_d   = phase_q;
    read_d    = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    pressed_d = pressed_q;
    press_d   = 8'h00;
    release_d = 8'h00;
    repeat_d  = 8'h00;
    rpt_d     = rpt_q;

    case (state_q)
      S_IDLE: begin
        // Timer parks on its terminal count until the decoder reports idle.
        if (poll_en) begin
          if (timer_q == TIMER_LAST) begin
            if (ready_to_read) begin
              state_d = S_REQ;
              timer_d = '0;
              read_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT_BUSY;
        phase_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!ready_to_read) begin
          state_d = S_WAIT_DONE;
          phase_d = '0;
        end else if (phase_q == PHASE_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (ready_to_read) begin
          state_d = S_CAPTURE;
        end else if (phase_q == PHASE_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_CAPTURE: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        pressed_d = w_new;
        press_d   = w_new & ~pressed_q;
        release_d = pressed_q & ~w_new;
        for (int i = 0; i < 8; i++) begin
          if (w_new[i] != pressed_q[i]) begin
            rpt_d[i] = 8'h00;
          end else if (w_new[i]) begin
            // Reload keeps subsequent repeats REPEAT_RATE captures apart.
            if (rpt_q[i] == RPT_TOP - 8'd1) begin
              repeat_d[i] = 1'b1;
              rpt_d[i]    = RPT_RELOAD;
            end else begin
              rpt_d[i] = rpt_q[i] + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      phase_q   <= '0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      pressed_q <= 8'h00;
      press_q   <= 8'h00;
      release_q <= 8'h00;
      repeat_q  <= 8'h00;
      for (int i = 0; i < 8; i++) rpt_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      read_q    <= read_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      rpt_q     <= rpt_d;
    end
  end

  assign read_data   = read_q;
  assign pressed     = pressed_q;
  assign press_evt   = press_q;
  assign release_evt = release_q;
  assign repeat_evt  = repeat_q;
  assign poll_done   = done_q;
  assign timeout_evt = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_input_events.sv
// ============================================================================
// Module   : tb_nes_input_events
// Purpose  : Self-checking bench for nes_input_events with a decoder model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nes_input_events;

  localparam int P   = 16;
  localparam int TO  = 8;
  localparam int RD  = 30;
  localparam int RR  = 6;
  localparam int CAP_BUDGET = P + 3 * TO + 10;

  logic       in_clock = 1'b0;
  logic       reset = 1'b1;
  logic       poll_en = 1'b1;
  logic       ready_to_read = 1'b1;
  logic [7:0] buttons_n = 8'hFF;
  logic       read_data;
  logic [7:0] pressed, press_evt, release_evt, repeat_evt;
  logic       poll_done, timeout_evt;

  int n_checks = 0;
  int n_fail   = 0;
  // 0 normal handshake, 1 never goes busy, 2 hold ready low, 3 long busy
  int dec_mode = 0;

  // Reference: held level per button and number of consecutive held captures.
  logic [7:0] mp = 8'h00;
  int         hc [8];

  nes_input_events #(
    .POLL_PERIOD (P),
    .TIMEOUT     (TO),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .in_clock     (in_clock),
    .reset        (reset),
    .poll_en      (poll_en),
    .ready_to_read(ready_to_read),
    .buttons_n    (buttons_n),
    .read_data    (read_data),
    .pressed      (pressed),
    .press_evt    (press_evt),
    .release_evt  (release_evt),
    .repeat_evt   (repeat_evt),
    .poll_done    (poll_done),
    .timeout_evt  (timeout_evt)
  );

  always #5 in_clock = ~in_clock;

  // Decoder model: after a read request it goes busy for a while, then idle.
  initial begin
    int lat, busy;
    forever begin
      @(negedge in_clock);
      if (dec_mode == 2) begin
        ready_to_read = 1'b0;
      end else begin
        ready_to_read = 1'b1;
        if (read_data && dec_mode != 1 && !reset) begin
          lat  = (dec_mode == 3) ? 0 : int'($urandom_range(0, 2));
          busy = (dec_mode == 3) ? 10 : int'($urandom_range(1, 4));
          repeat (lat) @(negedge in_clock);
          ready_to_read = 1'b0;
          repeat (busy) @(negedge in_clock);
          ready_to_read = 1'b1;
        end
      end
    end
  end

  function automatic void model_reset();
    mp = 8'h00;
    for (int i = 0; i < 8; i++) hc[i] = 0;
  endfunction

  // A held button repeats on its (RD+1)th capture and every RR captures after.
  function automatic void model_capture(input logic [7:0] nw, output logic [7:0] ep,
                                        output logic [7:0] er, output logic [7:0] erp);
    ep = 8'h00; er = 8'h00; erp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (nw[i]) begin
        if (!mp[i]) begin
          hc[i] = 1;
          ep[i] = 1'b1;
        end else begin
          hc[i] = hc[i] + 1;
        end
        if (hc[i] >= RD + 1 && ((hc[i] - RD - 1) % RR) == 0) erp[i] = 1'b1;
      end else begin
        if (mp[i]) er[i] = 1'b1;
        hc[i] = 0;
      end
    end
    mp = nw;
  endfunction

  task automatic wait_for(input int sel, input int budget, output int n, output bit hit);
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      @(posedge in_clock);
      #1;
      n++;
      case (sel)
        0:       hit = read_data;
        1:       hit = poll_done;
        default: hit = timeout_evt;
      endcase
    end
  endtask

  task automatic test_reset();
    int n; bit hit;
    reset = 1'b1;
    repeat (2) @(posedge in_clock);
    #1;
    n_checks++;
    if ({read_data, pressed, press_evt, release_evt, repeat_evt, poll_done, timeout_evt} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b pr=%h pe=%h re=%h rp=%h pd=%b to=%b, want all 0",
               read_data, pressed, press_evt, release_evt, repeat_evt, poll_done, timeout_evt);
    end
    @(negedge in_clock);
    reset = 1'b0;
    model_reset();
    wait_for(0, P + 5, n, hit);
    n_checks++;
    if (!hit || n != P) begin
      n_fail++;
      $display("FAIL first_read: read_data after %0d cycles (seen=%0b), want %0d", n, hit, P);
    end
    @(posedge in_clock);
    #1;
    n_checks++;
    if (read_data !== 1'b0) begin
      n_fail++;
      $display("FAIL read_width: read_data=%b one cycle later, want 0", read_data);
    end
  endtask

  task automatic test_press_release();
    int n; bit hit; logic [7:0] ep, er, erp;
    buttons_n = 8'hFE;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || {pressed, press_evt, release_evt} !== {8'h01, 8'h01, 8'h00} || ep !== 8'h01) begin
      n_fail++;
      $display("FAIL press_A: seen=%0b pressed=%h press=%h release=%h, want 01 01 00",
               hit, pressed, press_evt, release_evt);
    end
    @(posedge in_clock);
    #1;
    n_checks++;
    if ({press_evt, poll_done} !== 9'h0) begin
      n_fail++;
      $display("FAIL press_width: press=%h poll_done=%b next cycle, want 00 0", press_evt, poll_done);
    end
    buttons_n = 8'hFF;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || {pressed, press_evt, release_evt} !== {8'h00, 8'h00, 8'h01}) begin
      n_fail++;
      $display("FAIL release_A: seen=%0b pressed=%h press=%h release=%h, want 00 00 01",
               hit, pressed, press_evt, release_evt);
    end
  endtask

  task automatic test_random_buttons();
    int n; bit hit; logic [7:0] ep, er, erp;
    for (int k = 0; k < 14; k++) begin
      buttons_n = 8'($urandom);
      if (k == 3) buttons_n = 8'h00;
      wait_for(1, CAP_BUDGET, n, hit);
      model_capture(~buttons_n, ep, er, erp);
      n_checks++;
      if (!hit || {pressed, press_evt, release_evt, repeat_evt} !== {mp, ep, er, erp}) begin
        n_fail++;
        $display("FAIL random_capture[%0d]: seen=%0b got pr=%h pe=%h re=%h rp=%h want %h %h %h %h",
                 k, hit, pressed, press_evt, release_evt, repeat_evt, mp, ep, er, erp);
      end
    end
  endtask

  task automatic test_repeat();
    int n; bit hit; logic [7:0] ep, er, erp; logic [7:0] want;
    buttons_n = 8'hFF;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    buttons_n = 8'hEF;
    for (int c = 1; c <= 45; c++) begin
      wait_for(1, CAP_BUDGET, n, hit);
      model_capture(~buttons_n, ep, er, erp);
      want = (c == 31 || c == 37 || c == 43) ? 8'h10 : 8'h00;
      n_checks++;
      if (!hit || repeat_evt !== want || erp !== want || pressed !== 8'h10) begin
        n_fail++;
        $display("FAIL repeat_up[%0d]: seen=%0b repeat=%h pressed=%h, want repeat=%h pressed=10",
                 c, hit, repeat_evt, pressed, want);
      end
    end
  endtask

  task automatic test_timeout();
    int n; bit hit; bit saw_done; logic [7:0] ep, er, erp;
    dec_mode = 1;
    wait_for(0, P + 5, n, hit);
    saw_done = 1'b0;
    n = 0;
    hit = 1'b0;
    while (!hit && n < TO + 6) begin
      @(posedge in_clock);
      #1;
      n++;
      if (poll_done) saw_done = 1'b1;
      hit = timeout_evt;
    end
    dec_mode = 0;
    n_checks++;
    if (!hit || n != TO + 1 || saw_done || pressed !== mp) begin
      n_fail++;
      $display("FAIL timeout: seen=%0b after %0d cycles done=%0b pressed=%h, want %0d cycles no done pressed=%h",
               hit, n, saw_done, pressed, TO + 1, mp);
    end
    wait_for(0, P + 5, n, hit);
    n_checks++;
    if (!hit || n != P) begin
      n_fail++;
      $display("FAIL timeout_next_read: read after %0d cycles (seen=%0b), want %0d", n, hit, P);
    end
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || {pressed, press_evt, release_evt, repeat_evt} !== {mp, ep, er, erp}) begin
      n_fail++;
      $display("FAIL after_timeout_capture: got %h %h %h %h want %h %h %h %h",
               pressed, press_evt, release_evt, repeat_evt, mp, ep, er, erp);
    end
  endtask

  task automatic test_poll_period();
    int n; bit hit; logic [7:0] ep, er, erp;
    for (int k = 0; k < 3; k++) begin
      wait_for(1, CAP_BUDGET, n, hit);
      model_capture(~buttons_n, ep, er, erp);
      wait_for(0, P + 5, n, hit);
      n_checks++;
      if (!hit || n != P) begin
        n_fail++;
        $display("FAIL poll_period[%0d]: read %0d cycles after poll_done (seen=%0b), want %0d", k, n, hit, P);
      end
    end
    // Disabling mid-transaction still lets the capture finish.
    poll_en = 1'b0;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || pressed !== mp) begin
      n_fail++;
      $display("FAIL disable_mid_txn: poll_done seen=%0b pressed=%h, want 1 %h", hit, pressed, mp);
    end
    wait_for(0, 2 * P, n, hit);
    n_checks++;
    if (hit) begin
      n_fail++;
      $display("FAIL disabled_read: read_data=1 while poll_en=0, want 0");
    end
    poll_en = 1'b1;
    wait_for(0, P + 5, n, hit);
    n_checks++;
    if (!hit || n != P) begin
      n_fail++;
      $display("FAIL reenable_read: read after %0d cycles (seen=%0b), want %0d", n, hit, P);
    end
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
  endtask

  task automatic test_reset_mid();
    int n; bit hit; logic [7:0] ep, er, erp;
    buttons_n = 8'h7E;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || pressed !== 8'h81) begin
      n_fail++;
      $display("FAIL preset_81: seen=%0b pressed=%h, want 81", hit, pressed);
    end
    dec_mode = 3;
    wait_for(0, P + 5, n, hit);
    repeat (3) @(posedge in_clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({read_data, pressed, press_evt, release_evt, repeat_evt, poll_done, timeout_evt} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got rd=%b pr=%h pe=%h re=%h rp=%h pd=%b to=%b, want all 0",
               read_data, pressed, press_evt, release_evt, repeat_evt, poll_done, timeout_evt);
    end
    @(negedge in_clock);
    reset = 1'b0;
    dec_mode = 0;
    model_reset();
    wait_for(0, P + 5, n, hit);
    n_checks++;
    if (!hit || n != P) begin
      n_fail++;
      $display("FAIL reset_mid_read: read after %0d cycles (seen=%0b), want %0d", n, hit, P);
    end
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || {pressed, press_evt} !== {8'h81, 8'h81}) begin
      n_fail++;
      $display("FAIL reset_mid_repress: seen=%0b pressed=%h press=%h, want 81 81", hit, pressed, press_evt);
    end
  endtask

  task automatic test_not_ready();
    int n; bit hit; int highs; logic [7:0] ep, er, erp;
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    dec_mode = 2;
    highs = 0;
    for (int c = 0; c < P + 6; c++) begin
      @(posedge in_clock);
      #1;
      if (read_data) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL not_ready_hold: read_data high %0d cycles while not ready, want 0", highs);
    end
    dec_mode = 0;
    @(posedge in_clock);
    #1;
    n_checks++;
    if (read_data !== 1'b1) begin
      n_fail++;
      $display("FAIL not_ready_release: read_data=%b one cycle after ready, want 1", read_data);
    end
    wait_for(1, CAP_BUDGET, n, hit);
    model_capture(~buttons_n, ep, er, erp);
    n_checks++;
    if (!hit || {pressed, press_evt, release_evt, repeat_evt} !== {mp, ep, er, erp}) begin
      n_fail++;
      $display("FAIL not_ready_capture: seen=%0b got %h %h %h %h want %h %h %h %h",
               hit, pressed, press_evt, release_evt, repeat_evt, mp, ep, er, erp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_random_buttons();
    test_repeat();
    test_timeout();
    test_poll_period();
    test_reset_mid();
    test_not_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
